// File: rtl/cpu_irq_pkg.sv
// Shared types and helpers for the interrupt request path.
// onehot_n is the same code-to-line mapping the select decoder uses.
package cpu_irq_pkg;
    localparam int IRQ_N = 4;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PRESENT,
        IRQ_RETIRE
    } irq_state_t;

    function automatic logic [31:0] onehot_n(input logic [4:0] code);
        onehot_n = 32'd1 << code;
    endfunction
endpackage

// File: rtl/prio_enc_2pn_n.sv
// Combinational 2^N-to-N encoder; the highest set index wins.
// An all-zero input gives code 0 with any_set low.
module prio_enc_2pn_n #(
    parameter int N = 4
) (
    input  logic [(1<<N)-1:0] in_vec,
    output logic [N-1:0]      code,
    output logic              any_set
);
    always_comb begin
        code    = '0;
        any_set = 1'b0;
        for (int i = 0; i < (1 << N); i++) begin
            if (in_vec[i]) begin
                code    = N'(i);
                any_set = 1'b1;
            end
        end
    end
endmodule

// File: rtl/irq_priority_encoder.sv
// Sticky edge-triggered request collector presenting the highest-index
// unmasked pending line as an N-bit code over a valid/ack handshake.
module irq_priority_encoder
    import cpu_irq_pkg::*;
#(
    parameter int N = IRQ_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [(1<<N)-1:0]   req,
    input  logic                mask_we,
    input  logic [(1<<N)-1:0]   mask_in,
    input  logic                ack,
    output logic                valid,
    output logic [N-1:0]        code,
    output logic [(1<<N)-1:0]   pending
);
    localparam int W = 1 << N;

    irq_state_t  state_q, state_d;
    logic [W-1:0] req_q, req_d;
    logic [W-1:0] pending_q, pending_d;
    logic [W-1:0] mask_q, mask_d;
    logic [N-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic         armed_q, armed_d;

    logic [W-1:0] rise;
    logic [W-1:0] clr;
    logic [W-1:0] eligible;
    logic [N-1:0] enc_code;
    logic         enc_any;

    prio_enc_2pn_n #(.N(N)) u_enc (
        .in_vec  (eligible),
        .code    (enc_code),
        .any_set (enc_any)
    );

    always_comb begin
        // armed_q is low for the first cycle after reset so lines already high are not edges
        rise      = armed_q ? (req & ~req_q) : '0;
        eligible  = pending_q & mask_q;
        clr       = '0;
        req_d     = req;
        armed_d   = 1'b1;
        mask_d    = mask_we ? mask_in : mask_q;
        state_d   = state_q;
        valid_d   = valid_q;
        code_d    = code_q;

        case (state_q)
            IRQ_IDLE: begin
                if (enc_any) begin
                    state_d = IRQ_PRESENT;
                    valid_d = 1'b1;
                    code_d  = enc_code;
                end
            end
            IRQ_PRESENT: begin
                if (ack) begin
                    state_d = IRQ_RETIRE;
                    valid_d = 1'b0;
                    clr     = W'(onehot_n(5'(code_q)));
                end
            end
            IRQ_RETIRE: begin
                state_d = IRQ_IDLE;
            end
            default: begin
                state_d = IRQ_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // a new edge in the same cycle as its retirement keeps the line pending
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IRQ_IDLE;
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            code_q    <= '0;
            valid_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            armed_q   <= armed_d;
        end
    end

    assign valid   = valid_q;
    assign code    = code_q;
    assign pending = pending_q;
endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed bench for irq_priority_encoder at N=2, 3 and 4 with a code scoreboard on N=4.
module tb_irq_priority_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0] req4 = '0, mask_in4 = '0, pending4;
    logic        mask_we4 = 1'b0, ack4 = 1'b0, valid4;
    logic [3:0]  code4;

    logic [7:0]  req3 = '0, mask_in3 = '0, pending3;
    logic        mask_we3 = 1'b0, ack3 = 1'b0, valid3;
    logic [2:0]  code3;

    logic [3:0]  req2 = '0, mask_in2 = '0, pending2;
    logic        mask_we2 = 1'b0, ack2 = 1'b0, valid2;
    logic [1:0]  code2;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    irq_priority_encoder #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .mask_we(mask_we4), .mask_in(mask_in4),
        .ack(ack4), .valid(valid4), .code(code4), .pending(pending4)
    );
    irq_priority_encoder #(.N(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .mask_we(mask_we3), .mask_in(mask_in3),
        .ack(ack3), .valid(valid3), .code(code3), .pending(pending3)
    );
    irq_priority_encoder #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .mask_we(mask_we2), .mask_in(mask_in2),
        .ack(ack2), .valid(valid2), .code(code2), .pending(pending2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_v4(input string tag, output int n);
        n = 0;
        while (!valid4 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, valid4}, 32'd1);
    endtask

    task automatic pop_chk4(input string tag);
        logic [31:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_code"}, {28'd0, code4}, exp);
        end else begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
    endtask

    task automatic serve4(input string tag);
        int n;
        wait_v4(tag, n);
        pop_chk4(tag);
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        chk({tag, "_bubble"}, {31'd0, valid4}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset with every request line held high; release must not register edges
        rst = 1'b1; req4 = '1; req3 = '1; req2 = '1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid4", {31'd0, valid4}, 32'd0);
        chk("rst_code4", {28'd0, code4}, 32'd0);
        chk("rst_pend4", {16'd0, pending4}, 32'd0);
        chk("rst_valid3", {31'd0, valid3}, 32'd0);
        chk("rst_pend3", {24'd0, pending3}, 32'd0);
        chk("rst_valid2", {31'd0, valid2}, 32'd0);
        chk("rst_pend2", {28'd0, pending2}, 32'd0);
        req4 = '0; req3 = '0; req2 = '0;
        tick();

        // N=3 single request, exact latency
        req3 = 8'h10;
        tick();
        chk("single_pend", {24'd0, pending3}, 32'h10);
        chk("single_notyet", {31'd0, valid3}, 32'd0);
        tick();
        chk("single_valid", {31'd0, valid3}, 32'd1);
        chk("single_code", {29'd0, code3}, 32'd4);
        ack3 = 1'b1;
        tick();
        ack3 = 1'b0;
        chk("single_retire", {31'd0, valid3}, 32'd0);
        chk("single_clear", {24'd0, pending3}, 32'd0);

        // N=2 two lines, higher first
        req2 = 4'b0101;
        tick(); tick();
        chk("n2_valid_a", {31'd0, valid2}, 32'd1);
        chk("n2_code_a", {30'd0, code2}, 32'd2);
        ack2 = 1'b1; tick(); ack2 = 1'b0;
        tick(); tick();
        chk("n2_valid_b", {31'd0, valid2}, 32'd1);
        chk("n2_code_b", {30'd0, code2}, 32'd0);
        ack2 = 1'b1; tick(); ack2 = 1'b0;
        chk("n2_clear", {28'd0, pending2}, 32'd0);

        // N=4 priority order with back-to-back latency
        req4 = 16'h8204;
        exp_q.push_back(15); exp_q.push_back(9); exp_q.push_back(2);
        serve4("prio0");
        wait_v4("prio_b2b", n);
        chk("prio_b2b_cycles", n, 32'd2);
        serve4("prio1");
        serve4("prio2");
        req4 = '0;
        tick();

        // hold: presented code is frozen against higher-priority arrivals
        req4 = 16'h0004;
        exp_q.push_back(2); exp_q.push_back(7);
        wait_v4("hold_wait", n);
        req4 = 16'h0084;
        tick(); tick();
        chk("hold_code", {28'd0, code4}, 32'd2);
        chk("hold_valid", {31'd0, valid4}, 32'd1);
        serve4("hold0");
        serve4("hold1");
        req4 = '0;
        tick();

        // mask: line 15 stays pending while masked, ack with valid low is ignored
        mask_we4 = 1'b1; mask_in4 = 16'h7FFF; tick(); mask_we4 = 1'b0;
        req4 = 16'h8002;
        exp_q.push_back(1);
        serve4("mask_low");
        tick(); tick();
        chk("mask_blocked", {31'd0, valid4}, 32'd0);
        chk("mask_pend", {16'd0, pending4}, 32'h8000);
        ack4 = 1'b1; tick(); ack4 = 1'b0; tick();
        chk("ack_idle_pend", {16'd0, pending4}, 32'h8000);
        chk("ack_idle_valid", {31'd0, valid4}, 32'd0);
        mask_we4 = 1'b1; mask_in4 = 16'hFFFF; tick(); mask_we4 = 1'b0;
        exp_q.push_back(15);
        serve4("unmask");
        chk("unmask_clear", {16'd0, pending4}, 32'd0);
        req4 = '0;
        tick();

        // collision: retirement of line 5 coincides with a fresh edge on line 5
        req4 = 16'h0020;
        exp_q.push_back(5);
        wait_v4("coll_wait", n);
        pop_chk4("coll_first");
        req4 = '0;
        tick();
        req4 = 16'h0020; ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        chk("coll_pend", {16'd0, pending4}, 32'h0020);
        chk("coll_bubble", {31'd0, valid4}, 32'd0);
        exp_q.push_back(5);
        serve4("coll_re");
        chk("coll_clear", {16'd0, pending4}, 32'd0);
        req4 = '0;
        tick();

        // reset during presentation drops the in-flight code
        req4 = 16'h0008;
        exp_q.push_back(3);
        wait_v4("mid_wait", n);
        pop_chk4("mid_code");
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_valid", {31'd0, valid4}, 32'd0);
        chk("mid_rst_code", {28'd0, code4}, 32'd0);
        chk("mid_rst_pend", {16'd0, pending4}, 32'd0);
        tick(); tick(); tick();
        chk("mid_rst_noedge", {16'd0, pending4}, 32'd0);
        chk("mid_rst_idle", {31'd0, valid4}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
